// File: rtl/ram_readback_checker.sv
// Walks every RAM address once, compares each returned word against (address XOR seed)
// and reports a pass flag, the number of mismatches and the first failing address.
module ram_readback_checker #(
    parameter int DATA_WIDTH   = 8,
    parameter int N_WORDS      = 16,
    parameter int READ_LATENCY = 1,
    localparam int AW = $clog2(N_WORDS),
    localparam int CW = $clog2(N_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [AW-1:0]         ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CW-1:0]         error_count,
    output logic [AW-1:0]         first_err_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N_WORDS - 1);

    state_t                  state_q, state_d;
    logic                    ramRe_q, ramRe_d;
    logic [AW-1:0]           ramAddr_q, ramAddr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [CW-1:0]           errCount_q, errCount_d;
    logic [AW-1:0]           firstErr_q, firstErr_d;
    logic [DATA_WIDTH-1:0]   seed_q, seed_d;

    logic [READ_LATENCY-1:0] validPipe_q;
    logic [AW-1:0]           addrPipe_q [READ_LATENCY];

    logic                    cmpValid;
    logic [AW-1:0]           cmpAddr;
    logic [DATA_WIDTH-1:0]   addrWord;
    logic [DATA_WIDTH-1:0]   expWord;
    logic                    mismatch;

    // The pipeline mirrors the RAM's read latency, so the tail entry lines up with ram_data_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            validPipe_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                addrPipe_q[i] <= '0;
            end
        end else begin
            validPipe_q[0] <= ramRe_q;
            addrPipe_q[0]  <= ramAddr_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                validPipe_q[i] <= validPipe_q[i-1];
                addrPipe_q[i]  <= addrPipe_q[i-1];
            end
        end
    end

    assign cmpValid = validPipe_q[READ_LATENCY-1];
    assign cmpAddr  = addrPipe_q[READ_LATENCY-1];

    generate
        if (AW >= DATA_WIDTH) begin : gTruncAddr
            assign addrWord = cmpAddr[DATA_WIDTH-1:0];
        end else begin : gExtendAddr
            assign addrWord = {{(DATA_WIDTH - AW){1'b0}}, cmpAddr};
        end
    endgenerate

    assign expWord  = addrWord ^ seed_q;
    assign mismatch = cmpValid && (ram_data_out != expWord);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ramRe_q    <= 1'b0;
            ramAddr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            errCount_q <= '0;
            firstErr_q <= '0;
            seed_q     <= '0;
        end else begin
            state_q    <= state_d;
            ramRe_q    <= ramRe_d;
            ramAddr_q  <= ramAddr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            errCount_q <= errCount_d;
            firstErr_q <= firstErr_d;
            seed_q     <= seed_d;
        end
    end

    // Next-state logic; the pass verdict uses errCount_d so a mismatch on the last word still counts.
    always_comb begin
        state_d    = state_q;
        ramRe_d    = ramRe_q;
        ramAddr_d  = ramAddr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        errCount_d = errCount_q;
        firstErr_d = firstErr_q;
        seed_d     = seed_q;

        if (mismatch) begin
            errCount_d = errCount_q + CW'(1);
            if (errCount_q == '0) begin
                firstErr_d = cmpAddr;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = READ;
                    seed_d     = seed;
                    errCount_d = '0;
                    pass_d     = 1'b0;
                    ramRe_d    = 1'b1;
                    ramAddr_d  = '0;
                    busy_d     = 1'b1;
                end
            end
            READ: begin
                if (ramAddr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                    ramRe_d = 1'b0;
                end else begin
                    ramAddr_d = ramAddr_q + AW'(1);
                end
            end
            DRAIN: begin
                if (cmpValid && (cmpAddr == LAST_ADDR)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (errCount_d == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ram_we         = 1'b0;
    assign ram_data_in    = '0;
    assign ram_re         = ramRe_q;
    assign ram_address    = ramAddr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign error_count    = errCount_q;
    assign first_err_addr = firstErr_q;

endmodule

// File: tb/tb_ram_readback_checker.sv
// Scoreboard bench for ram_readback_checker: one instance at read latency 1, one at latency 3,
// each driven against its own behavioural RAM.
module tb_ram_readback_checker;

   typedef struct {
      int cyc;
      int pass;
      int errs;
      int first;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   int         cyc = 0;

   logic       start1, start3;
   logic [7:0] seed1, seed3;
   logic       we1, re1, busy1, done1, pass1;
   logic       we3, re3, busy3, done3, pass3;
   logic [3:0] addr1, fea1, addr3, fea3;
   logic [7:0] din1, dout1, din3, dout3;
   logic [4:0] ec1, ec3;
   logic [7:0] mem1 [16];
   logic [7:0] mem3 [16];
   logic [7:0] p3a, p3b;

   exp_t q1[$];
   exp_t q3[$];
   int   checks = 0;
   int   errors = 0;
   bit   weBad = 1'b0;

   ram_readback_checker #(.DATA_WIDTH(8), .N_WORDS(16), .READ_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .seed(seed1),
      .ram_we(we1), .ram_re(re1), .ram_address(addr1), .ram_data_in(din1),
      .ram_data_out(dout1), .busy(busy1), .done(done1), .pass(pass1),
      .error_count(ec1), .first_err_addr(fea1)
   );

   ram_readback_checker #(.DATA_WIDTH(8), .N_WORDS(16), .READ_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .seed(seed3),
      .ram_we(we3), .ram_re(re3), .ram_address(addr3), .ram_data_in(din3),
      .ram_data_out(dout3), .busy(busy3), .done(done3), .pass(pass3),
      .error_count(ec3), .first_err_addr(fea3)
   );

   // Free-running clock and a cycle index used to time-stamp expected done pulses.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural RAMs: one-cycle and three-cycle read paths.
   always @(posedge clk) dout1 <= mem1[addr1];

   always @(posedge clk) begin
      p3a   <= mem3[addr3];
      p3b   <= p3a;
      dout3 <= p3b;
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flagFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got event expected none (cycle %0d)", name, cyc);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: each done pulse pops the oldest expectation for that instance and compares.
   always @(negedge clk) begin
      if (we1 !== 1'b0 || din1 !== 8'h00 || we3 !== 1'b0 || din3 !== 8'h00) weBad = 1'b1;
      if (done1 === 1'b1) begin
         if (q1.size() == 0) begin
            flagFail("dut1_unexpected_done");
         end else begin
            exp_t e;
            e = q1.pop_front();
            checkOutput("dut1_done_cycle", cyc, e.cyc);
            checkOutput("dut1_pass", int'(pass1), e.pass);
            checkOutput("dut1_error_count", int'(ec1), e.errs);
            checkOutput("dut1_busy_at_done", int'(busy1), 0);
            if (e.errs != 0) checkOutput("dut1_first_err_addr", int'(fea1), e.first);
         end
      end
      if (done3 === 1'b1) begin
         if (q3.size() == 0) begin
            flagFail("dut3_unexpected_done");
         end else begin
            exp_t e;
            e = q3.pop_front();
            checkOutput("dut3_done_cycle", cyc, e.cyc);
            checkOutput("dut3_pass", int'(pass3), e.pass);
            checkOutput("dut3_error_count", int'(ec3), e.errs);
            if (e.errs != 0) checkOutput("dut3_first_err_addr", int'(fea3), e.first);
         end
      end
   end

   // Pulses start on the chosen instance and pushes the hand-computed result (expPass < 0: none).
   task automatic applyStimulus(input int dutSel, input logic [7:0] s, input int expPass,
                                input int expErrs, input int expFirst, output int sCyc);
      exp_t e;
      @(posedge clk);
      #1;
      sCyc = cyc;
      if (dutSel == 1) begin
         start1 = 1'b1;
         seed1  = s;
      end else begin
         start3 = 1'b1;
         seed3  = s;
      end
      if (expPass >= 0) begin
         e.cyc   = sCyc + ((dutSel == 1) ? 18 : 20);
         e.pass  = expPass;
         e.errs  = expErrs;
         e.first = expFirst;
         if (dutSel == 1) q1.push_back(e);
         else q3.push_back(e);
      end
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      for (int i = 0; i < budget && (q1.size() != 0 || q3.size() != 0); i++) @(posedge clk);
      if (q1.size() != 0 || q3.size() != 0) begin
         flagFail("done_timeout");
         q1.delete();
         q3.delete();
      end
      waitCycles(2);
   endtask

   task automatic fillMem(input int dutSel, input logic [7:0] x);
      for (int a = 0; a < 16; a++) begin
         if (dutSel == 1) mem1[a] = 8'(a) ^ x;
         else mem3[a] = 8'(a) ^ x;
      end
   endtask

   initial begin
      int s;
      rst    = 1'b1;
      start1 = 1'b0;
      start3 = 1'b0;
      seed1  = 8'h00;
      seed3  = 8'h00;
      fillMem(1, 8'h00);
      fillMem(3, 8'h00);
      waitCycles(3);

      checkOutput("reset_ram_re", int'(re1), 0);
      checkOutput("reset_ram_address", int'(addr1), 0);
      checkOutput("reset_busy", int'(busy1), 0);
      checkOutput("reset_done", int'(done1), 0);
      checkOutput("reset_pass", int'(pass1), 0);
      checkOutput("reset_error_count", int'(ec1), 0);
      rst = 1'b0;
      waitCycles(2);

      // Clean pass, with the read window and DRAIN hold checked directly.
      applyStimulus(1, 8'h00, 1, 0, 0, s);
      checkOutput("re_first_cycle", int'(re1), 1);
      checkOutput("addr_first_cycle", int'(addr1), 0);
      checkOutput("busy_first_cycle", int'(busy1), 1);
      waitCycles(15);
      checkOutput("re_last_cycle", int'(re1), 1);
      checkOutput("addr_last_cycle", int'(addr1), 15);
      waitCycles(1);
      checkOutput("re_drain", int'(re1), 0);
      checkOutput("addr_drain_hold", int'(addr1), 15);
      checkOutput("busy_drain", int'(busy1), 1);
      waitDrain(60);

      // Single corrupted word.
      mem1[5] = 8'hFF;
      applyStimulus(1, 8'h00, 0, 1, 5, s);
      waitDrain(60);

      // Seeded pattern, then the same contents against seed 0: every word differs.
      fillMem(1, 8'hA5);
      applyStimulus(1, 8'hA5, 1, 0, 0, s);
      waitDrain(60);
      applyStimulus(1, 8'h00, 0, 16, 0, s);
      waitDrain(60);

      // Mid-READ pulse is ignored; start held across DRAIN/DONE launches pass two at S+19.
      fillMem(1, 8'h00);
      applyStimulus(1, 8'h00, 1, 0, 0, s);
      waitCycles(4);
      start1 = 1'b1;
      waitCycles(1);
      start1 = 1'b0;
      waitCycles(11);
      start1 = 1'b1;
      begin
         exp_t e;
         e.cyc = s + 37; e.pass = 1; e.errs = 0; e.first = 0;
         q1.push_back(e);
      end
      waitCycles(2);
      checkOutput("busy_idle_after_done", int'(busy1), 0);
      waitCycles(1);
      start1 = 1'b0;
      checkOutput("second_pass_re", int'(re1), 1);
      checkOutput("second_pass_addr", int'(addr1), 0);
      waitDrain(80);

      // Reset at S+8 with bad words in flight: no done, no late compare.
      mem1[6] = 8'hFF;
      mem1[7] = 8'hFF;
      mem1[8] = 8'hFF;
      applyStimulus(1, 8'h00, -1, 0, 0, s);
      waitCycles(7);
      rst = 1'b1;
      waitCycles(1);
      checkOutput("midreset_ram_re", int'(re1), 0);
      checkOutput("midreset_busy", int'(busy1), 0);
      checkOutput("midreset_address", int'(addr1), 0);
      checkOutput("midreset_error_count", int'(ec1), 0);
      checkOutput("midreset_first_err_addr", int'(fea1), 0);
      rst = 1'b0;
      waitCycles(3);
      checkOutput("midreset_no_late_compare", int'(ec1), 0);
      waitCycles(20);
      fillMem(1, 8'h00);
      applyStimulus(1, 8'h00, 1, 0, 0, s);
      waitDrain(60);

      // Three-cycle RAM: clean pass, then a fault on the very last address.
      applyStimulus(3, 8'h00, 1, 0, 0, s);
      waitDrain(60);
      mem3[15] = 8'h00;
      applyStimulus(3, 8'h00, 0, 1, 15, s);
      waitDrain(60);

      checkOutput("ram_we_and_data_in_zero", int'(weBad), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_readback_checker.md
RAM_READBACK_CHECKER -- requirements
Module: ram_readback_checker

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the RAM word width in bits.
REQ-002 The module SHALL have parameter N_WORDS, default 16, giving the RAM depth; address width AW = $clog2(N_WORDS).
REQ-003 The module SHALL have parameter READ_LATENCY, default 1, legal range 1..4, giving the cycles from a read request to valid RAM data.
REQ-004 The module SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  The single clock; all state updates on its rising edge.
REQ-006 rst  input  1  Synchronous, active-high reset.
REQ-007 start  input  1  Single-cycle request to begin a readback pass; sampled only in IDLE.
REQ-008 seed  input  DATA_WIDTH  Pattern seed; captured when start is accepted.
REQ-009 ram_we  output  1  RAM write enable; always 0.
REQ-010 ram_re  output  1  RAM read enable.
REQ-011 ram_address  output  AW  RAM address.
REQ-012 ram_data_in  output  DATA_WIDTH  RAM write data; always 0.
REQ-013 ram_data_out  input  DATA_WIDTH  RAM read data, valid READ_LATENCY cycles after the cycle in which ram_re=1.
REQ-014 busy  output  1  High from the cycle after start is accepted until done is asserted, exclusive of the done cycle.
REQ-015 done  output  1  Single-cycle pulse at the end of a pass.
REQ-016 pass  output  1  1 when the last completed pass had zero mismatches; held until the next start.
REQ-017 error_count  output  $clog2(N_WORDS+1)  Mismatch count of the current or last pass.
REQ-018 first_err_addr  output  AW  Address of the first mismatch in the pass; valid when error_count != 0.

Function
REQ-019 The expected word for address a SHALL be (a zero-extended or truncated to DATA_WIDTH) XOR the captured seed.
REQ-020 The FSM SHALL have states IDLE, READ, DRAIN and DONE.
REQ-021 IDLE -> READ SHALL occur when start=1 in IDLE; at that edge seed is captured, error_count is cleared to 0 and pass is cleared to 0.
REQ-022 In READ, ram_re=1 every cycle, with ram_address = 0, 1, ..., N_WORDS-1 on consecutive cycles.
REQ-023 READ -> DRAIN SHALL occur after address N_WORDS-1 is issued.
REQ-024 In DRAIN, ram_re=0 and ram_address holds its last value.
REQ-025 The block SHALL track each issued address through a READ_LATENCY-deep address/valid pipeline.
REQ-026 The block SHALL compare ram_data_out against the expected word exactly when the pipeline valid emerges.
REQ-027 On a mismatch, error_count SHALL increment by 1; on the first mismatch of a pass, first_err_addr SHALL be loaded.
REQ-028 DRAIN -> DONE SHALL occur after the compare for address N_WORDS-1.
REQ-029 In DONE, done=1 for one cycle and pass = (error_count == 0), then the FSM returns to IDLE.
REQ-030 Latency: if start is sampled in cycle S, done SHALL be high in cycle S+N_WORDS+READ_LATENCY+1.
REQ-031 start SHALL be ignored while busy or in DONE; a held-high start SHALL launch a new pass on the first IDLE cycle.
REQ-032 All outputs SHALL be registered.
REQ-033 error_count SHALL never exceed N_WORDS, so no wrap or saturation logic is needed.

Reset
REQ-034 rst=1 SHALL force within one edge: state IDLE, ram_re=0, ram_we=0, ram_address=0, ram_data_in=0, busy=0, done=0, pass=0, error_count=0, first_err_addr=0, pipeline valids=0.
REQ-035 Reset asserted mid-pass SHALL abort the pass without a done pulse.
REQ-036 After a mid-pass reset, late RAM data still in flight SHALL NOT be compared.

Verification
REQ-037 Defaults, RAM prefilled with mem[a]=a, seed=0, start pulse in cycle S -> ram_re high in cycles S+1..S+16; done at S+18; pass=1; error_count=0.
REQ-038 Same fill, mem[5] corrupted to 8'hFF -> done at S+18; pass=0; error_count=1; first_err_addr=5.
REQ-039 RAM filled with a XOR 8'hA5 and seed=8'hA5 -> pass=1; then rerun with seed=0 -> error_count=16 and first_err_addr=0.
REQ-040 start re-pulsed during READ, and start held high across DONE -> the mid-READ pulse is ignored; the second pass begins in the IDLE cycle after done.
REQ-041 rst asserted in cycle S+8 for one cycle -> all outputs reset next edge; no done pulse; a subsequent clean pass gives pass=1.
REQ-042 READ_LATENCY=3 with a matching RAM model -> done at S+20; pass=1; ram_we stays 0 throughout.
